pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_pc_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// pc_sequencer -- program counter sequencer with conditional branches,
// register jumps, halt/stall control and an optional return-address stack.
//
// Optional feature macro: PC_SEQ_RAS_EN
//   defined   : return-address stack, call/ret handling, overflow/underflow flags
//   undefined : call ignored, ret is a no-op, ras_overflow/ras_underflow tied to 0
//
// Ports
//   clk           : single clock, all state updates on the rising edge
//   rst           : asynchronous active-low reset
//   stall         : hold the PC this cycle, every other input ignored
//   hlt           : hold the PC and enter the sticky halted state
//   branch        : current instruction is a control transfer
//   cond          : branch condition code
//   Z, N, V       : zero / negative / overflow flags
//   addr_src      : 1 = PC-relative immediate target, 0 = register target
//   imm           : signed branch offset in instructions
//   reg_target    : absolute register target
//   call, ret     : push / pop of the return stack
//   pc            : current PC
//   pc_next_seq   : pc + INSTR_BYTES (combinational)
//   halted, ras_overflow, ras_underflow : sticky status, cleared by reset only
module pc_sequencer #(
  parameter int ADDR_W      = 16,
  parameter int IMM_W       = 9,
  parameter int INSTR_BYTES = 2,
  parameter int RAS_DEPTH   = 4,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              hlt,
  input  logic              branch,
  input  logic [2:0]        cond,
  input  logic              Z,
  input  logic              N,
  input  logic              V,
  input  logic              addr_src,
  input  logic [IMM_W-1:0]  imm,
  input  logic [ADDR_W-1:0] reg_target,
  input  logic              call,
  input  logic              ret,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next_seq,
  output logic              halted,
  output logic              ras_overflow,
  output logic              ras_underflow
);

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              taken;
  logic [ADDR_W-1:0] imm_sext;
  logic [ADDR_W-1:0] target;

  assign pc_next_seq = pc_q + ADDR_W'(INSTR_BYTES);

  // Sign-extending size cast, then scale; unsigned multiply gives the
  // correct two's-complement product modulo 2^ADDR_W.
  assign imm_sext = ADDR_W'($signed(imm));
  assign target   = addr_src ? (pc_next_seq + imm_sext * ADDR_W'(INSTR_BYTES))
                             : reg_target;

  always_comb begin
    taken = 1'b0;
    case (cond)
      3'b000: taken = !Z;
      3'b001: taken = Z;
      3'b010: taken = !Z && !N;
      3'b011: taken = N;
      3'b100: taken = !N;
      3'b101: taken = Z || N;
      3'b110: taken = V;
      default: taken = 1'b1;
    endcase
    taken = taken && branch;
  end

`ifdef PC_SEQ_RAS_EN
  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Circular buffer: sp points at the next free slot. When full, a push
  // lands on the oldest entry, which is exactly the overwrite we want.
  logic [ADDR_W-1:0] ras_mem [RAS_DEPTH];
  logic [PTR_W-1:0]  sp_q, sp_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              ras_we;
  logic [ADDR_W-1:0] ras_top;

  // The pop must redirect in the same cycle, so the top is read
  // combinationally (small distributed memory).
  assign ras_top = ras_mem[sp_q - PTR_W'(1)];

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    sp_d    = sp_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    ras_we  = 1'b0;
    if (state_q == ST_HALT || stall) begin
      pc_d = pc_q;
    end else if (hlt) begin
      state_d = ST_HALT;
    end else if (ret) begin
      // A simultaneous call is dropped: ret wins outright.
      if (cnt_q != '0) begin
        pc_d  = ras_top;
        sp_d  = sp_q - PTR_W'(1);
        cnt_d = cnt_q - CNT_W'(1);
      end else begin
        pc_d  = pc_next_seq;
        unf_d = 1'b1;
      end
    end else if (taken) begin
      pc_d = target;
      if (call) begin
        ras_we = 1'b1;
        sp_d   = sp_q + PTR_W'(1);
        if (cnt_q == CNT_W'(RAS_DEPTH)) ovf_d = 1'b1;
        else                            cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      pc_d = pc_next_seq;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_ADDR;
      state_q <= ST_RUN;
      sp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      sp_q    <= sp_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Storage carries no reset; emptiness is tracked by cnt_q alone.
  always_ff @(posedge clk) begin
    if (rst && ras_we) ras_mem[sp_q] <= pc_next_seq;
  end

  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;
`else
  logic ras_unused;
  assign ras_unused = &{1'b0, call, ret};

  always_comb begin
    pc_d    = pc_q;
    state_d = state_q;
    if (state_q == ST_HALT || stall) begin
      pc_d = pc_q;
    end else if (hlt) begin
      state_d = ST_HALT;
    end else if (taken) begin
      pc_d = target;
    end else begin
      pc_d = pc_next_seq;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q    <= RESET_ADDR;
      state_q <= ST_RUN;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
    end
  end

  assign ras_overflow  = 1'b0;
  assign ras_underflow = 1'b0;
`endif

  assign pc     = pc_q;
  assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer -- directed scoreboard bench for pc_sequencer.
// Stimulus applies inputs after each falling edge and queues the expected
// post-edge state; a monitor pops and compares one entry after every
// rising edge.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, hlt, branch, Z, N, V, addr_src, call, ret;
  logic [2:0]  cond;
  logic [8:0]  imm;
  logic [15:0] reg_target;
  logic [15:0] pc, pc_next_seq;
  logic        halted, ras_overflow, ras_underflow;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    string       nm;
    logic [15:0] pc;
    logic        h;
    logic        o;
    logic        u;
  } exp_t;

  exp_t sb[$];

  logic exp_h, exp_o, exp_u;
  logic [15:0] exp_pc;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .stall(stall), .hlt(hlt), .branch(branch),
    .cond(cond), .Z(Z), .N(N), .V(V), .addr_src(addr_src), .imm(imm),
    .reg_target(reg_target), .call(call), .ret(ret), .pc(pc),
    .pc_next_seq(pc_next_seq), .halted(halted),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic chk_all(input exp_t e);
    chk({e.nm, ".pc"},       pc,                    e.pc);
    chk({e.nm, ".pc_next"},  pc_next_seq,           e.pc + 16'd2);
    chk({e.nm, ".halted"},   {15'd0, halted},        {15'd0, e.h});
    chk({e.nm, ".ovf"},      {15'd0, ras_overflow},  {15'd0, e.o});
    chk({e.nm, ".unf"},      {15'd0, ras_underflow}, {15'd0, e.u});
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk_all(e);
        $display("txn %-14s pc=%h next=%h halted=%b ovf=%b unf=%b",
                 e.nm, pc, pc_next_seq, halted, ras_overflow, ras_underflow);
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    stall = 0; hlt = 0; branch = 0; cond = 3'b000; Z = 0; N = 0; V = 0;
    addr_src = 0; imm = '0; reg_target = '0; call = 0; ret = 0;
  endtask

  task automatic issue(input string nm, input logic [15:0] p);
    exp_t e;
    e.nm = nm; e.pc = p; e.h = exp_h; e.o = exp_o; e.u = exp_u;
    exp_pc = p;
    sb.push_back(e);
  endtask

  task automatic jmp_reg(input string nm, input logic [15:0] t);
    tick(); branch = 1; cond = 3'b111; addr_src = 0; reg_target = t;
    issue(nm, t);
  endtask

  // {cond, Z, N, V, taken}
  logic [6:0] vec [17];

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    vec = '{7'b000_000_1, 7'b000_100_0, 7'b001_100_1, 7'b001_000_0,
            7'b010_000_1, 7'b010_010_0, 7'b010_100_0, 7'b011_010_1,
            7'b011_000_0, 7'b100_000_1, 7'b100_010_0, 7'b101_100_1,
            7'b101_010_1, 7'b101_000_0, 7'b110_001_1, 7'b110_000_0,
            7'b111_000_1};
    exp_h = 0; exp_o = 0; exp_u = 0; exp_pc = 0;
    rst = 0;
    stall = 0; hlt = 0; branch = 0; cond = 3'b000; Z = 0; N = 0; V = 0;
    addr_src = 0; imm = '0; reg_target = '0; call = 0; ret = 0;

    // Reset held across edges, then release
    tick(); branch = 1; cond = 3'b111; reg_target = 16'h0abc; issue("rst_hold0", 16'h0000);
    tick(); issue("rst_hold1", 16'h0000);
    tick(); rst = 1; issue("first_seq", 16'h0002);

    // Conditional branch at 0x0002, cond=000 imm=5
    tick(); branch = 1; cond = 3'b000; addr_src = 1; imm = 9'd5; Z = 1;
    issue("bne_not_taken", 16'h0004);
    tick(); branch = 1; cond = 3'b000; addr_src = 1; imm = 9'd5; Z = 0;
    issue("bne_taken", 16'h0010);

`ifdef PC_SEQ_RAS_EN
    tick(); branch = 1; cond = 3'b111; addr_src = 1; imm = 9'd8; call = 1;
    issue("call", 16'h0022);
    tick(); ret = 1; issue("ret", 16'h0012);
    tick(); ret = 1; exp_u = 1; issue("ret_empty", 16'h0014);
`else
    tick(); branch = 1; cond = 3'b111; addr_src = 1; imm = 9'd8; call = 1;
    issue("call_ignored", 16'h0022);
    tick(); ret = 1; issue("ret_noop", 16'h0024);
    tick(); ret = 1; branch = 1; cond = 3'b111; reg_target = 16'h0040;
    issue("ret_plus_jmp", 16'h0040);
`endif

    jmp_reg("reg_jump", 16'h0100);

`ifdef PC_SEQ_RAS_EN
    // Five pushes into four entries: oldest (0x0102) is lost
    for (int i = 0; i < 5; i++) begin
      tick(); branch = 1; cond = 3'b111; addr_src = 1; imm = '0; call = 1;
      if (i == 4) exp_o = 1;
      issue("call_fill", exp_pc + 16'd2);
    end
    tick(); ret = 1; issue("pop_10a", 16'h010a);
    tick(); ret = 1; issue("pop_108", 16'h0108);
    tick(); ret = 1; issue("pop_106", 16'h0106);
    tick(); ret = 1; issue("pop_104", 16'h0104);
    tick(); ret = 1; issue("pop_empty", 16'h0106);
    tick(); branch = 1; cond = 3'b111; addr_src = 1; imm = 9'd4; call = 1;
    issue("call_push108", 16'h0110);
    tick(); branch = 1; cond = 3'b111; addr_src = 1; imm = 9'd4; call = 1; ret = 1;
    issue("call_and_ret", 16'h0108);
    tick(); ret = 1; issue("ret_after_both", 16'h010a);
`endif

    // Condition-code table with register targets
    jmp_reg("cond_base", 16'h0200);
    for (int i = 0; i < 17; i++) begin
      logic [15:0] t;
      t = 16'h0300 + 16'(i * 16);
      tick(); branch = 1; cond = vec[i][6:4]; Z = vec[i][3]; N = vec[i][2];
      V = vec[i][1]; addr_src = 0; reg_target = t;
      issue($sformatf("cond%0d_%0d", vec[i][6:4], i), vec[i][0] ? t : exp_pc + 16'd2);
    end
    tick(); branch = 0; cond = 3'b111; reg_target = 16'h0777;
    issue("no_branch", exp_pc + 16'd2);

    // Wrap
    jmp_reg("to_fffe", 16'hfffe);
    tick(); issue("wrap_seq", 16'h0000);
    tick(); branch = 1; cond = 3'b111; addr_src = 1; imm = 9'h1ff;
    issue("imm_minus1", 16'h0000);

    // Stall and halt
    jmp_reg("to_0040", 16'h0040);
    tick(); stall = 1; branch = 1; cond = 3'b111; reg_target = 16'h0500;
    issue("stall_branch", 16'h0040);
    tick(); stall = 1; hlt = 1; issue("stall_over_hlt", 16'h0040);
    tick(); hlt = 1; exp_h = 1; issue("halt", 16'h0040);
    jmp_reg("halted_jmp", 16'h0040);
    tick(); branch = 1; cond = 3'b111; addr_src = 1; imm = 9'd3;
    issue("halted_jmp2", 16'h0040);

    // Reset asserted mid-cycle: takes effect without a clock edge
    tick(); branch = 1; cond = 3'b111; reg_target = 16'h0080;
    #2; rst = 0; #1;
    exp_h = 0; exp_o = 0; exp_u = 0;
    chk_all('{nm: "async_rst", pc: 16'h0000, h: 1'b0, o: 1'b0, u: 1'b0});
    $display("txn %-14s pc=%h halted=%b", "async_rst", pc, halted);
    issue("rst_hold2", 16'h0000);
    tick(); rst = 1; issue("rerelease", 16'h0002);
    tick();

    for (int k = 0; k < 5 && sb.size() != 0; k++) @(posedge clk);
    #2;
    if (sb.size() != 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
